// File: rtl/axi_burst_arbiter_if.sv
// AXI4 bundle (32-bit address/data, 4-bit id) shared by the arbiter's requester and memory ports.
// master modport drives requests and ready for responses; slave modport is the mirror image.
interface axi_if;
   logic        awvalid;
   logic        awready;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic [3:0]  awid;
   logic        wvalid;
   logic        wready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        bvalid;
   logic        bready;
   logic [1:0]  bresp;
   logic [3:0]  bid;
   logic        arvalid;
   logic        arready;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [3:0]  arid;
   logic        rvalid;
   logic        rready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic [3:0]  rid;

   modport master (
      output awvalid, awaddr, awlen, awsize, awburst, awid,
      input  awready,
      output wvalid, wdata, wstrb, wlast,
      input  wready,
      input  bvalid, bresp, bid,
      output bready,
      output arvalid, araddr, arlen, arsize, arburst, arid,
      input  arready,
      input  rvalid, rdata, rresp, rlast, rid,
      output rready
   );

   modport slave (
      input  awvalid, awaddr, awlen, awsize, awburst, awid,
      output awready,
      input  wvalid, wdata, wstrb, wlast,
      output wready,
      output bvalid, bresp, bid,
      input  bready,
      input  arvalid, araddr, arlen, arsize, arburst, arid,
      output arready,
      output rvalid, rdata, rresp, rlast, rid,
      input  rready
   );
endinterface

// File: rtl/axi_burst_arbiter.sv
// Round-robin I$/D$ arbiter locking the shared AXI port for one whole transaction; grant 1 cycle after request.
// Channels are combinational pass-through while granted; the non-owner simply sees ready/valid low.
module axi_burst_arbiter #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   axi_if.master                m_axi,
   axi_if.slave                 s_axi_instr,
   axi_if.slave                 s_axi_data,
   output logic                 busy,
   output logic                 owner,
   output logic [CNT_WIDTH-1:0] instr_txn_cnt,
   output logic [CNT_WIDTH-1:0] data_txn_cnt,
   output logic                 resp_err
);
   typedef enum logic [1:0] {IDLE, RD, WR, WR_RESP} state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_t state;
   logic   last_grant;
   logic   req_i, req_d, winner, win_aw;
   logic   act, rd_on, aw_on, w_on;
   logic   r_last_hs, r_err, wl_hs, b_hs, b_err;

   assign req_i  = s_axi_instr.arvalid | s_axi_instr.awvalid;
   assign req_d  = s_axi_data.arvalid | s_axi_data.awvalid;
   assign winner = (req_i & req_d) ? ~last_grant : req_d;
   assign win_aw = winner ? s_axi_data.awvalid : s_axi_instr.awvalid;

   assign act   = (state != IDLE);
   assign rd_on = (state == RD);
   assign aw_on = (state == WR) || (state == WR_RESP);
   assign w_on  = (state == WR);

   // Outgoing port: owner's request fields, idle defaults otherwise
   assign m_axi.arvalid = rd_on & (owner ? s_axi_data.arvalid : s_axi_instr.arvalid);
   assign m_axi.araddr  = rd_on ? (owner ? s_axi_data.araddr : s_axi_instr.araddr) : 32'd0;
   assign m_axi.arlen   = act ? (owner ? s_axi_data.arlen : s_axi_instr.arlen) : 8'd127;
   assign m_axi.arsize  = act ? (owner ? s_axi_data.arsize : s_axi_instr.arsize) : 3'b010;
   assign m_axi.arburst = act ? (owner ? s_axi_data.arburst : s_axi_instr.arburst) : 2'b01;
   assign m_axi.arid    = act ? (owner ? s_axi_data.arid : s_axi_instr.arid) : 4'd0;
   assign m_axi.rready  = rd_on & (owner ? s_axi_data.rready : s_axi_instr.rready);

   assign m_axi.awvalid = aw_on & (owner ? s_axi_data.awvalid : s_axi_instr.awvalid);
   assign m_axi.awaddr  = aw_on ? (owner ? s_axi_data.awaddr : s_axi_instr.awaddr) : 32'd0;
   assign m_axi.awlen   = act ? (owner ? s_axi_data.awlen : s_axi_instr.awlen) : 8'd127;
   assign m_axi.awsize  = act ? (owner ? s_axi_data.awsize : s_axi_instr.awsize) : 3'b010;
   assign m_axi.awburst = act ? (owner ? s_axi_data.awburst : s_axi_instr.awburst) : 2'b01;
   assign m_axi.awid    = act ? (owner ? s_axi_data.awid : s_axi_instr.awid) : 4'd0;

   assign m_axi.wvalid  = w_on & (owner ? s_axi_data.wvalid : s_axi_instr.wvalid);
   assign m_axi.wdata   = w_on ? (owner ? s_axi_data.wdata : s_axi_instr.wdata) : 32'd0;
   assign m_axi.wstrb   = act ? (owner ? s_axi_data.wstrb : s_axi_instr.wstrb) : 4'hF;
   assign m_axi.wlast   = w_on & (owner ? s_axi_data.wlast : s_axi_instr.wlast);
   assign m_axi.bready  = aw_on & (owner ? s_axi_data.bready : s_axi_instr.bready);

   // Requester ports: payloads shared, handshake strobes only to the owner
   assign s_axi_instr.arready = rd_on & ~owner & m_axi.arready;
   assign s_axi_instr.rvalid  = rd_on & ~owner & m_axi.rvalid;
   assign s_axi_instr.rdata   = m_axi.rdata;
   assign s_axi_instr.rresp   = m_axi.rresp;
   assign s_axi_instr.rlast   = m_axi.rlast;
   assign s_axi_instr.rid     = m_axi.rid;
   assign s_axi_instr.awready = aw_on & ~owner & m_axi.awready;
   assign s_axi_instr.wready  = w_on & ~owner & m_axi.wready;
   assign s_axi_instr.bvalid  = aw_on & ~owner & m_axi.bvalid;
   assign s_axi_instr.bresp   = m_axi.bresp;
   assign s_axi_instr.bid     = m_axi.bid;

   assign s_axi_data.arready = rd_on & owner & m_axi.arready;
   assign s_axi_data.rvalid  = rd_on & owner & m_axi.rvalid;
   assign s_axi_data.rdata   = m_axi.rdata;
   assign s_axi_data.rresp   = m_axi.rresp;
   assign s_axi_data.rlast   = m_axi.rlast;
   assign s_axi_data.rid     = m_axi.rid;
   assign s_axi_data.awready = aw_on & owner & m_axi.awready;
   assign s_axi_data.wready  = w_on & owner & m_axi.wready;
   assign s_axi_data.bvalid  = aw_on & owner & m_axi.bvalid;
   assign s_axi_data.bresp   = m_axi.bresp;
   assign s_axi_data.bid     = m_axi.bid;

   assign r_last_hs = m_axi.rvalid & m_axi.rready & m_axi.rlast;
   assign r_err     = m_axi.rvalid & m_axi.rready & (m_axi.rresp != 2'b00);
   assign wl_hs     = m_axi.wvalid & m_axi.wready & m_axi.wlast;
   assign b_hs      = m_axi.bvalid & m_axi.bready;
   assign b_err     = b_hs & (m_axi.bresp != 2'b00);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         owner         <= 1'b0;
         last_grant    <= 1'b1;
         busy          <= 1'b0;
         instr_txn_cnt <= '0;
         data_txn_cnt  <= '0;
         resp_err      <= 1'b0;
      end else begin
         if (r_err || b_err) resp_err <= 1'b1;
         case (state)
            IDLE: begin
               if (req_i || req_d) begin
                  owner      <= winner;
                  last_grant <= winner;
                  busy       <= 1'b1;
                  state      <= win_aw ? WR : RD;
               end
            end
            RD: begin
               if (r_last_hs) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  if (owner) data_txn_cnt  <= data_txn_cnt + CNT_ONE;
                  else       instr_txn_cnt <= instr_txn_cnt + CNT_ONE;
               end
            end
            WR: begin
               if (wl_hs) state <= WR_RESP;
            end
            WR_RESP: begin
               if (b_hs) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  if (owner) data_txn_cnt  <= data_txn_cnt + CNT_ONE;
                  else       instr_txn_cnt <= instr_txn_cnt + CNT_ONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi_burst_arbiter.sv
// Directed bench: tb plays both cache masters and a always-ready memory slave around the arbiter.
module tb_axi_burst_arbiter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        busy, owner, resp_err;
   logic [31:0] instr_txn_cnt, data_txn_cnt;

   axi_if mm();
   axi_if im();
   axi_if dm();

   int checks = 0;
   int errors = 0;
   int i_rbeats = 0, d_rbeats = 0, d_wbeats = 0;
   int d_wsent = 0, d_wlen = 0, rd_left = 0;
   bit d_saw_rvalid = 1'b0;
   bit err_inject = 1'b0;

   always #5 clk = ~clk;

   axi_burst_arbiter #(.CNT_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .m_axi(mm), .s_axi_instr(im), .s_axi_data(dm),
      .busy(busy), .owner(owner), .instr_txn_cnt(instr_txn_cnt),
      .data_txn_cnt(data_txn_cnt), .resp_err(resp_err)
   );

   task automatic init_signals();
      im.awvalid = 0; im.awaddr = 0; im.awlen = 0; im.awsize = 3'b010; im.awburst = 2'b01; im.awid = 4'd0;
      im.wvalid = 0; im.wdata = 0; im.wstrb = 4'hF; im.wlast = 0; im.bready = 1;
      im.arvalid = 0; im.araddr = 0; im.arlen = 0; im.arsize = 3'b010; im.arburst = 2'b01; im.arid = 4'd0;
      im.rready = 1;
      dm.awvalid = 0; dm.awaddr = 0; dm.awlen = 0; dm.awsize = 3'b010; dm.awburst = 2'b01; dm.awid = 4'd1;
      dm.wvalid = 0; dm.wdata = 32'hD0; dm.wstrb = 4'hF; dm.wlast = 0; dm.bready = 1;
      dm.arvalid = 0; dm.araddr = 0; dm.arlen = 0; dm.arsize = 3'b010; dm.arburst = 2'b01; dm.arid = 4'd1;
      dm.rready = 1;
      mm.awready = 1; mm.wready = 1; mm.bvalid = 0; mm.bresp = 2'b00; mm.bid = 4'd0;
      mm.arready = 1; mm.rvalid = 0; mm.rdata = 0; mm.rresp = 2'b00; mm.rlast = 0; mm.rid = 4'd0;
   endtask

   // Masters drop valid after handshake; slave streams R beats and answers each write with one B.
   initial begin : agent
      bit i_ar, d_ar, d_aw, d_w, d_wl, i_r, d_r, s_ar, s_r, s_wl, s_b;
      logic [7:0] s_len;
      forever begin
         @(negedge clk);
         i_ar = im.arvalid & im.arready;
         d_ar = dm.arvalid & dm.arready;
         d_aw = dm.awvalid & dm.awready;
         d_w  = dm.wvalid & dm.wready;
         d_wl = d_w & dm.wlast;
         i_r  = im.rvalid & im.rready;
         d_r  = dm.rvalid & dm.rready;
         s_ar = mm.arvalid & mm.arready;
         s_r  = mm.rvalid & mm.rready;
         s_wl = mm.wvalid & mm.wready & mm.wlast;
         s_b  = mm.bvalid & mm.bready;
         s_len = mm.arlen;
         if (dm.rvalid) d_saw_rvalid = 1'b1;
         @(posedge clk);
         #1;
         if (!rst_n) begin
            rd_left = 0; mm.rvalid = 0; mm.rlast = 0; mm.rresp = 2'b00; mm.bvalid = 0;
            dm.wvalid = 0; dm.wlast = 0;
            i_rbeats = 0; d_rbeats = 0; d_wbeats = 0;
         end else begin
            if (i_r) i_rbeats++;
            if (d_r) d_rbeats++;
            if (i_ar) im.arvalid = 0;
            if (d_ar) dm.arvalid = 0;
            if (d_aw) dm.awvalid = 0;
            if (d_w) begin
               d_wbeats++;
               d_wsent++;
               if (d_wl) dm.wvalid = 0;
               dm.wlast = dm.wvalid && (d_wsent == d_wlen - 1);
            end
            if (s_r) rd_left--;
            if (s_ar) rd_left = int'(s_len) + 1;
            mm.rvalid = (rd_left > 0);
            mm.rlast  = (rd_left == 1);
            mm.rresp  = (rd_left == 1 && err_inject) ? 2'b10 : 2'b00;
            mm.rdata  = 32'(rd_left);
            if (s_b) mm.bvalid = 0;
            if (s_wl) mm.bvalid = 1;
         end
      end
   end

   task automatic do_reset();
      rst_n = 0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1;
      @(posedge clk);
      #2;
   endtask

   task automatic wait_busy(input logic lvl, input int max, output int n);
      n = 0;
      while (busy !== lvl && n < max) begin
         @(posedge clk);
         #2;
         n++;
      end
   endtask

   task automatic test_reset();
      rst_n = 0;
      @(posedge clk);
      #2;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
      checks++; if (owner !== 1'b0) begin errors++; $display("FAIL reset_owner got %0b exp 0", owner); end
      checks++; if (instr_txn_cnt !== 32'd0 || data_txn_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", instr_txn_cnt, data_txn_cnt); end
      checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err got %0b exp 0", resp_err); end
      checks++; if ({mm.arvalid, mm.awvalid, mm.wvalid, mm.rready, mm.bready} !== 5'b0) begin errors++; $display("FAIL reset_m_vld_rdy got %b exp 00000", {mm.arvalid, mm.awvalid, mm.wvalid, mm.rready, mm.bready}); end
      checks++; if ({im.arready, im.rvalid, dm.awready, dm.wready, dm.bvalid} !== 5'b0) begin errors++; $display("FAIL reset_s_vld_rdy got %b exp 00000", {im.arready, im.rvalid, dm.awready, dm.wready, dm.bvalid}); end
      checks++; if (mm.arlen !== 8'd127 || mm.awlen !== 8'd127) begin errors++; $display("FAIL idle_len got %0d/%0d exp 127/127", mm.arlen, mm.awlen); end
      checks++; if (mm.arsize !== 3'b010 || mm.arburst !== 2'b01 || mm.wstrb !== 4'hF || mm.arid !== 4'd0) begin errors++; $display("FAIL idle_fields got size %b burst %b strb %h id %0d exp 010 01 f 0", mm.arsize, mm.arburst, mm.wstrb, mm.arid); end
      #2 rst_n = 1;
      @(posedge clk);
      #2;
   endtask

   task automatic test_single_read();
      int n;
      d_saw_rvalid = 0;
      im.araddr = 32'h1000; im.arlen = 8'd127; im.arvalid = 1;
      @(posedge clk);
      #2;
      checks++; if (mm.arvalid !== 1'b1 || mm.araddr !== 32'h1000) begin errors++; $display("FAIL rd_grant got arvalid %0b araddr %h exp 1 1000", mm.arvalid, mm.araddr); end
      checks++; if (busy !== 1'b1 || owner !== 1'b0) begin errors++; $display("FAIL rd_owner got busy %0b owner %0b exp 1 0", busy, owner); end
      wait_busy(1'b0, 400, n);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_idle_timeout got busy %0b exp 0", busy); end
      @(negedge clk);
      checks++; if (i_rbeats != 128) begin errors++; $display("FAIL rd_beats got %0d exp 128", i_rbeats); end
      checks++; if (d_saw_rvalid !== 1'b0) begin errors++; $display("FAIL rd_dcache_rvalid got %0b exp 0", d_saw_rvalid); end
      checks++; if (instr_txn_cnt !== 32'd1 || data_txn_cnt !== 32'd0) begin errors++; $display("FAIL rd_cnt got %0d/%0d exp 1/0", instr_txn_cnt, data_txn_cnt); end
   endtask

   task automatic test_contention();
      int n;
      logic exp_o;
      do_reset();
      im.araddr = 32'h2000; im.arlen = 8'd3;
      dm.araddr = 32'h3000; dm.arlen = 8'd3;
      im.arvalid = 1; dm.arvalid = 1;
      for (int k = 0; k < 4; k++) begin
         exp_o = (k % 2) != 0;
         wait_busy(1'b1, 50, n);
         checks++; if (busy !== 1'b1 || owner !== exp_o) begin errors++; $display("FAIL rr_owner txn %0d got busy %0b owner %0b exp 1 %0b", k, busy, owner, exp_o); end
         checks++; if (n != 1) begin errors++; $display("FAIL rr_grant_latency txn %0d got %0d cycles exp 1", k, n); end
         wait_busy(1'b0, 50, n);
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle_timeout txn %0d got busy %0b exp 0", k, busy); end
         if (k < 3) begin
            if (owner) dm.arvalid = 1;
            else       im.arvalid = 1;
         end else begin
            im.arvalid = 0; dm.arvalid = 0;
         end
      end
      @(negedge clk);
      checks++; if (instr_txn_cnt !== 32'd2 || data_txn_cnt !== 32'd2) begin errors++; $display("FAIL rr_cnt got %0d/%0d exp 2/2", instr_txn_cnt, data_txn_cnt); end
      checks++; if (i_rbeats != 8 || d_rbeats != 8) begin errors++; $display("FAIL rr_beats got %0d/%0d exp 8/8", i_rbeats, d_rbeats); end
   endtask

   task automatic test_wb_refill();
      int n;
      do_reset();
      dm.awaddr = 32'h4000; dm.awlen = 8'd127;
      d_wlen = 128; d_wsent = 0; dm.wlast = 0; dm.wvalid = 1; dm.awvalid = 1;
      dm.araddr = 32'h5000; dm.arlen = 8'd127; dm.arvalid = 1;
      wait_busy(1'b1, 10, n);
      checks++; if (owner !== 1'b1 || mm.awvalid !== 1'b1 || mm.arvalid !== 1'b0) begin errors++; $display("FAIL wb_first got owner %0b awvalid %0b arvalid %0b exp 1 1 0", owner, mm.awvalid, mm.arvalid); end
      wait_busy(1'b0, 600, n);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wb_idle_timeout got busy %0b exp 0", busy); end
      checks++; if (d_wbeats != 128 || data_txn_cnt !== 32'd1) begin errors++; $display("FAIL wb_done got beats %0d cnt %0d exp 128 1", d_wbeats, data_txn_cnt); end
      wait_busy(1'b1, 10, n);
      checks++; if (mm.arvalid !== 1'b1 || mm.araddr !== 32'h5000 || mm.awvalid !== 1'b0) begin errors++; $display("FAIL refill_grant got arvalid %0b araddr %h awvalid %0b exp 1 5000 0", mm.arvalid, mm.araddr, mm.awvalid); end
      wait_busy(1'b0, 600, n);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL refill_idle_timeout got busy %0b exp 0", busy); end
      @(negedge clk);
      checks++; if (d_rbeats != 128 || data_txn_cnt !== 32'd2 || instr_txn_cnt !== 32'd0) begin errors++; $display("FAIL refill_done got beats %0d cnt %0d/%0d exp 128 2/0", d_rbeats, data_txn_cnt, instr_txn_cnt); end
   endtask

   task automatic test_resp_err();
      int n;
      err_inject = 1;
      im.araddr = 32'h6000; im.arlen = 8'd7; im.arvalid = 1;
      wait_busy(1'b1, 10, n);
      checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL err_before got %0b exp 0", resp_err); end
      wait_busy(1'b0, 50, n);
      checks++; if (resp_err !== 1'b1) begin errors++; $display("FAIL err_set got %0b exp 1", resp_err); end
      err_inject = 0;
      dm.araddr = 32'h7000; dm.arlen = 8'd3; dm.arvalid = 1;
      wait_busy(1'b1, 10, n);
      wait_busy(1'b0, 50, n);
      checks++; if (resp_err !== 1'b1 || data_txn_cnt !== 32'd3) begin errors++; $display("FAIL err_sticky got err %0b cnt %0d exp 1 3", resp_err, data_txn_cnt); end
      do_reset();
      checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL err_clear got %0b exp 0", resp_err); end
   endtask

   task automatic test_reset_mid_burst();
      int n;
      im.araddr = 32'h8000; im.arlen = 8'd127; im.arvalid = 1;
      wait_busy(1'b1, 10, n);
      n = 0;
      while (i_rbeats < 40 && n < 200) begin
         @(posedge clk);
         #2;
         n++;
      end
      checks++; if (i_rbeats != 40) begin errors++; $display("FAIL mid_beats got %0d exp 40", i_rbeats); end
      rst_n = 0;
      #1;
      checks++; if (busy !== 1'b0 || instr_txn_cnt !== 32'd0) begin errors++; $display("FAIL mid_rst_state got busy %0b cnt %0d exp 0 0", busy, instr_txn_cnt); end
      checks++; if ({mm.arvalid, mm.rready, mm.awvalid, mm.wvalid, mm.bready, im.rvalid} !== 6'b0) begin errors++; $display("FAIL mid_rst_vld_rdy got %b exp 000000", {mm.arvalid, mm.rready, mm.awvalid, mm.wvalid, mm.bready, im.rvalid}); end
      repeat (2) @(posedge clk);
      #2 rst_n = 1;
      @(posedge clk);
      #2;
      dm.araddr = 32'h9000; dm.arlen = 8'd3; dm.arvalid = 1;
      wait_busy(1'b1, 10, n);
      checks++; if (busy !== 1'b1 || owner !== 1'b1 || mm.araddr !== 32'h9000) begin errors++; $display("FAIL post_rst_grant got busy %0b owner %0b araddr %h exp 1 1 9000", busy, owner, mm.araddr); end
      wait_busy(1'b0, 50, n);
      @(negedge clk);
      checks++; if (busy !== 1'b0 || d_rbeats != 4 || data_txn_cnt !== 32'd1 || instr_txn_cnt !== 32'd0) begin errors++; $display("FAIL post_rst_done got busy %0b beats %0d cnt %0d/%0d exp 0 4 1/0", busy, d_rbeats, data_txn_cnt, instr_txn_cnt); end
   endtask

   initial begin
      rst_n = 0;
      init_signals();
      #1;
      test_reset();
      test_single_read();
      test_contention();
      test_wb_refill();
      test_resp_err();
      test_reset_mid_burst();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end
endmodule
